// File: rtl/apb_master_gen_if.sv
// Bundles the APB master's command, response and APB signals.
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_sel/cmd_addr/cmd_wdata : command port
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout                  : completion port
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA                         : APB request
//   PRDATA_bus/PREADY_bus/PSLVERR_bus                        : per-slave returns
// Modports: master (the bridge) and slave (command source plus APB slaves).
interface apb_master_gen_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_WIDTH  = 2
);
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic                             cmd_write;
  logic [SEL_WIDTH-1:0]             cmd_sel;
  logic [ADDR_WIDTH-1:0]            cmd_addr;
  logic [DATA_WIDTH-1:0]            cmd_wdata;

  logic                             rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_rdata;
  logic                             rsp_err;
  logic                             rsp_timeout;

  logic [NUM_SLAVES-1:0]            PSEL;
  logic                             PENABLE;
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic                             PWRITE;
  logic [DATA_WIDTH-1:0]            PWDATA;

  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_bus;
  logic [NUM_SLAVES-1:0]            PREADY_bus;
  logic [NUM_SLAVES-1:0]            PSLVERR_bus;

  modport master (
    input  cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata,
    input  PRDATA_bus, PREADY_bus, PSLVERR_bus,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata,
    output PRDATA_bus, PREADY_bus, PSLVERR_bus,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_gen.sv
// Parametrised APB bridge master: runs single read/write commands as
// SETUP/ACCESS transfers to one of NUM_SLAVES slaves, muxes the selected
// slave's PRDATA/PREADY/PSLVERR internally, and reports slave errors,
// ACCESS timeouts and out-of-range slave selects on the response port.
// Ports:
//   PCLK   : clock, rising edge
//   PRESET : asynchronous active-high reset
//   bus    : apb_master_gen_if.master (command, response and APB signals)
module apb_master_gen #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_master_gen_if.master  bus
);

  // Counter only needs to reach TIMEOUT; keep at least one bit when disabled.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                 state_q,     state_d;
  logic [SEL_WIDTH-1:0]   sel_q,       sel_d;
  logic [ADDR_WIDTH-1:0]  paddr_q,     paddr_d;
  logic                   pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0]  pwdata_q,    pwdata_d;
  logic [NUM_SLAVES-1:0]  psel_q,      psel_d;
  logic                   penable_q,   penable_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q,   rsp_err_d;
  logic                   rsp_to_q,    rsp_to_d;

  logic                   sel_ready_c;
  logic                   sel_err_c;
  logic [DATA_WIDTH-1:0]  sel_rdata_c;
  logic [NUM_SLAVES-1:0]  cmd_onehot_c;
  logic                   cmd_in_range_c;
  logic [CNT_W-1:0]       cnt_inc_c;
  logic                   timeout_hit_c;

  // Return-path mux driven by the latched select; unselected slaves ignored.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_err_c   = 1'b0;
    sel_rdata_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        sel_ready_c = bus.PREADY_bus[i];
        sel_err_c   = bus.PSLVERR_bus[i];
        sel_rdata_c = bus.PRDATA_bus[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // One-hot decode of the incoming select; all-zero when out of range.
  always_comb begin
    cmd_onehot_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      cmd_onehot_c[i] = (bus.cmd_sel == SEL_WIDTH'(i));
    end
  end

  assign cmd_in_range_c = (32'(bus.cmd_sel) < NUM_SLAVES);
  assign cnt_inc_c      = cnt_q + CNT_W'(1);
  assign timeout_hit_c  = (TIMEOUT != 0) && (cnt_inc_c == CNT_W'(TIMEOUT));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    cnt_d       = cnt_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid) begin
          cmd_ready_d = 1'b0;
          sel_d       = bus.cmd_sel;
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_wdata;
          if (cmd_in_range_c) begin
            state_d = S_SETUP;
            psel_d  = cmd_onehot_c;
          end else begin
            // Decode error: straight to the response, no bus activity.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end

      S_ACCESS: begin
        // PREADY is tested first so it wins over a coincident timeout.
        if (sel_ready_c) begin
          state_d     = S_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err_c;
          rsp_rdata_d = (!pwrite_q && !sel_err_c) ? sel_rdata_c : '0;
        end else if (timeout_hit_c) begin
          state_d     = S_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        cnt_d       = '0;
      end

      default: begin
        state_d     = S_IDLE;
        psel_d      = '0;
        penable_d   = 1'b0;
        cnt_d       = '0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;

endmodule
